uart_xcvr: RTL
==============

# uart_xcvr

Parametrised full-duplex UART transceiver, the successor to the fixed 8N2 driver. It provides configurable data width, stop bits and oversampling, and an oversampled receiver with false-start rejection and break handling. Parity is optional and selected at compile time. It sits between the system bus logic (valid/ready byte interface) and the board-level TX/RX pins.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in baud.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits transmitted; 1 or 2.
- OVERSAMPLE, 16: receiver samples per bit; even, at least 8.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Used only when the parity macro is defined.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_valid  in  1  a byte is offered for transmission.
- tx_data  in  DATA_BITS  transmit word; LSB is sent first.
- tx_ready  out  1  transmitter can accept a word.
- tx  out  1  serial output; idles high.
- rx  in  1  serial input; asynchronous to clk.
- rx_valid  out  1  one-cycle pulse when a received frame completes.
- rx_data  out  DATA_BITS  last received word.
- rx_frame_err  out  1  stop bit of the last frame sampled low.
- rx_parity_err  out  1  parity mismatch on the last frame.
- rx_busy  out  1  receiver is inside a frame.

## Operation
- Derived constants:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer truncation. An elaboration error is raised if DIV < 1.
  - BIT_CYCLES = DIV*OVERSAMPLE.
  - P = 1 when parity is compiled in, else 0.
- **TX state machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.**
  - tx_ready = (state == IDLE). This is combinational from state.
  - A transfer is accepted on a clk edge where tx_valid && tx_ready. tx_data is latched and the bit-cycle counter is cleared at that edge.
  - Each bit lasts exactly BIT_CYCLES clk cycles. The counter wraps at BIT_CYCLES-1 and advances the bit index or state.
  - DATA shifts out DATA_BITS bits, LSB first.
  - PARITY sends the XOR of the data bits, inverted when PARITY_ODD = 1.
  - STOP drives tx high for STOP_BITS*BIT_CYCLES cycles.
  - tx_valid while tx_ready = 0 is ignored; the word is not queued.
- **RX front end:** rx passes through a 2-flop synchroniser, whose flops reset to 1. A tick divider counts 0..DIV-1 and is cleared on start detection. One tick is one oversample.
- **RX state machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE (or BREAK).**
  - IDLE: a synchronised rx = 0 moves to START and clears the tick count.
  - START: after OVERSAMPLE/2 ticks, if rx = 0, clear the tick count and go to DATA. If rx = 1, this is a false start: return to IDLE with no outputs changed.
  - DATA: sample every OVERSAMPLE ticks (mid-bit), LSB first, DATA_BITS samples.
  - PARITY: one mid-bit sample, compared against the computed parity.
  - STOP: one mid-bit sample. Only the first stop bit is checked, regardless of STOP_BITS.
  - On the stop sample edge: rx_data, rx_frame_err and rx_parity_err update and rx_valid pulses for one cycle. All three outputs hold until the next rx_valid.
  - If the stop bit was 0, go to BREAK; otherwise go to IDLE.
  - BREAK: wait until synchronised rx = 1, then go to IDLE. A held-low line therefore produces exactly one rx_valid.
- rx_busy = (state != IDLE).
- There is no receive backpressure. A frame not consumed is overwritten by the next one.
- TX and RX are independent. Simultaneous accept and receive completion is legal.

## Timing
- Reset values: tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, rx_frame_err = 0, rx_parity_err = 0, rx_busy = 0. Both FSMs go to IDLE.
- TX latency:
  - tx falls on the first clk edge after the accepting edge.
  - The frame occupies (1+DATA_BITS+P+STOP_BITS)*BIT_CYCLES cycles.
  - tx_ready rises on the edge that ends the last stop bit.
  - A new word accepted on that edge starts its start bit with no idle gap.
- RX latency: rx_valid asserts 2 (synchroniser) + (OVERSAMPLE/2 + (DATA_BITS+P+1)*OVERSAMPLE)*DIV cycles after the rx falling edge, with a tolerance of ±DIV cycles.
- Reset mid-frame: asserting rst aborts both FSMs immediately. tx returns high asynchronously and no rx_valid is produced.

## Configuration
- UART_PARITY_EN:
  - Defined: the PARITY state exists in both FSMs, P = 1, and rx_parity_err is computed.
  - Undefined: there is no parity bit on the line, P = 0, and rx_parity_err is tied to 0.

## Test plan
Test parameters: CLK_FREQ = 16_000_000, BAUD_RATE = 1_000_000, OVERSAMPLE = 16, so DIV = 1 and BIT_CYCLES = 16.
- **8N1 transmit:** tx_data = 0xA5 accepted -> tx reads 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. tx_ready is low for 160 cycles.
- **Loopback:** tx wired to rx; send 0x00, 0xFF, 0x3C back-to-back -> three rx_valid pulses with the matching rx_data and no error flags.
- **False start:** rx driven low for 5 cycles, then high -> no rx_valid, and rx_busy returns to 0 within 12 cycles.
- **Framing error and break:** 0x81 sent with the stop bit low, then rx held low for 100 cycles -> exactly one rx_valid with rx_frame_err = 1. The next good frame clears the flag.
- **Parity (UART_PARITY_EN, PARITY_ODD = 0):** tx 0x07 produces parity bit 1. Injecting a frame carrying 0x07 with parity 0 -> rx_parity_err = 1 and rx_data = 0x07.
- **Reset mid-frame:** rst asserted during data bit 3 of a transmission -> tx = 1 and tx_ready = 1 immediately. The next accepted word transmits a correct frame.

Source files
------------

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART transceiver.
// Transmitter takes words over a valid/ready handshake and serialises them LSB first.
// Receiver oversamples the line, rejects false starts, flags framing/parity errors and
// swallows a held-low line (break) as a single frame.
// Compile-time option: define UART_PARITY_EN to add a parity bit (odd when PARITY_ODD = 1).
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   tx_valid/tx_data  word offered for transmission; tx_ready high while the transmitter is idle
//   tx                serial output, idles high
//   rx                serial input, asynchronous to clk
//   rx_valid          one-cycle pulse when a frame completes
//   rx_data           last received word; rx_frame_err / rx_parity_err describe that word
//   rx_busy           receiver is inside a frame
module uart_xcvr #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);
  localparam int unsigned DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned BIT_CYCLES = DIV * OVERSAMPLE;
  localparam int unsigned CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned TW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OW         = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] BitLast    = CW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TickLast   = TW'(DIV - 1);
  localparam logic [OW-1:0] OsLast     = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OsHalfLast = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DataLast   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    StopLast   = 4'(STOP_BITS - 1);

  if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PARITY_ODD > 1) begin : gen_param_check
    $error("uart_xcvr: illegal parameter combination");
  end

`ifdef UART_PARITY_EN
  localparam logic ParOdd = (PARITY_ODD != 0);
`endif

  // ---------------------------------------------------------------- transmitter
  localparam logic [2:0] TxIdle = 3'd0, TxStart = 3'd1, TxData = 3'd2, TxParity = 3'd3,
                         TxStop = 3'd4;

  logic [2:0]           tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_q, tx_line, tx_par_bit;

`ifdef UART_PARITY_EN
  logic tx_par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_par_q <= 1'b0;
    end else if (tx_state_q == TxIdle && tx_valid) begin
      tx_par_q <= (^tx_data) ^ ParOdd;
    end
  end
  assign tx_par_bit = tx_par_q;
`else
  assign tx_par_bit = 1'b1;
`endif

  assign tx_ready = (tx_state_q == TxIdle);
  assign tx       = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    if (tx_state_q == TxIdle) begin
      if (tx_valid) begin
        tx_shreg_d = tx_data;
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = TxStart;
      end
    end else if (tx_cnt_q == BitLast) begin
      tx_cnt_d = '0;
      tx_idx_d = tx_idx_q + 4'd1;
      case (tx_state_q)
        TxStart: begin
          tx_idx_d   = '0;
          tx_state_d = TxData;
        end
        TxData: begin
          tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
          if (tx_idx_q == DataLast) begin
            tx_idx_d = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TxParity;
`else
            tx_state_d = TxStop;
`endif
          end
        end
        TxParity: begin
          tx_idx_d   = '0;
          tx_state_d = TxStop;
        end
        TxStop: begin
          if (tx_idx_q == StopLast) tx_state_d = TxIdle;
        end
        default: tx_state_d = TxIdle;
      endcase
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  // Line level for the current state; registered, so tx trails the state by one cycle.
  always_comb begin
    tx_line = 1'b1;
    case (tx_state_q)
      TxStart:  tx_line = 1'b0;
      TxData:   tx_line = tx_shreg_q[0];
      TxParity: tx_line = tx_par_bit;
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_q       <= tx_line;
    end
  end

  // ------------------------------------------------------------------- receiver
  localparam logic [2:0] RxIdle = 3'd0, RxStart = 3'd1, RxData = 3'd2, RxParity = 3'd3,
                         RxStop = 3'd4, RxBreak = 3'd5;

  logic [1:0]           rx_sync_q;
  logic                 rx_s, tick;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [OW-1:0]        os_cnt_q, os_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  assign rx_s = rx_sync_q[1];
  // Divider is held at zero while idle so the first oversample lines up with the start edge.
  assign tick = (tick_cnt_q == TickLast);

  always_comb begin
    rx_state_d = rx_state_q;
    os_cnt_d   = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    tick_cnt_d = (rx_state_q == RxIdle || tick) ? '0 : tick_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = rx_ferr_q;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      RxIdle: begin
        if (!rx_s) begin
          os_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (tick && os_cnt_q == OsHalfLast) begin
          os_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (tick && os_cnt_q == OsLast) begin
          os_cnt_d   = '0;
          rx_idx_d   = rx_idx_q + 4'd1;
          rx_shreg_d = {rx_s, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_idx_q == DataLast) begin
`ifdef UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end
        end
      end
      RxParity: begin
        if (tick && os_cnt_q == OsLast) begin
`ifdef UART_PARITY_EN
          rx_par_d = rx_s;
`endif
          os_cnt_d   = '0;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (tick && os_cnt_q == OsLast) begin
          os_cnt_d   = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shreg_q;
          rx_ferr_d  = !rx_s;
`ifdef UART_PARITY_EN
          rx_perr_d  = rx_par_q ^ (^rx_shreg_q) ^ ParOdd;
`endif
          rx_state_d = rx_s ? RxIdle : RxBreak;
        end
      end
      RxBreak: begin
        if (rx_s) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RxIdle;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_state_q <= rx_state_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_busy      = (rx_state_q != RxIdle);
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
